// File: rtl/xdma_pkg.sv
// Shared types for the XDMA write-request scheduler.
//   xdma_req_desc_t    : per-slot write request descriptor
//   xdma_req_idx_t     : request slot index (wide enough for up to 16 slots)
//   xdma_sched_state_e : scheduler state encoding
package xdma_pkg;

    typedef struct packed {
        logic [63:0] remote_addr;
        logic [63:0] local_addr;
        logic [31:0] dma_length;
    } xdma_req_desc_t;

    typedef logic [3:0] xdma_req_idx_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StRelease
    } xdma_sched_state_e;

endpackage

// File: rtl/xdma_rr_picker.sv
// Combinational round-robin first-one search.
// Scans valid_i starting at rr_ptr_i and wrapping modulo NumReq.
//   valid_i  : pending slot mask
//   rr_ptr_i : slot with highest priority this cycle
//   sel_o    : first pending slot at or after rr_ptr_i (0 when none)
//   any_o    : at least one slot is pending
module xdma_rr_picker #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   rr_ptr_i,
    output logic [IdxW-1:0]   sel_o,
    output logic              any_o
);

    int unsigned     idx;
    logic [IdxW-1:0] cand;

    always_comb begin
        sel_o = '0;
        any_o = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = 32'(rr_ptr_i) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            cand = IdxW'(idx);
            if (!any_o && valid_i[cand]) begin
                any_o = 1'b1;
                sel_o = cand;
            end
        end
    end

endmodule

// File: rtl/xdma_write_req_scheduler.sv
// Round-robin scheduler sharing one burst reshaper between NumReq write-request
// slots. A pending slot is granted in IDLE, its descriptor latched and held
// while valid is high (BUSY), and the slot is released for one cycle once the
// write datapath reports completion (RELEASE), after which priority rotates.
//
// Optional feature macro: XDMA_WRITE_SCHED_TIMEOUT_EN adds a BUSY watchdog of
// TimeoutCycles cycles that forces a release and pulses timeout_o.
//
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   req_desc_i / req_valid_i: per-slot descriptors and pending flags
//   req_release_o           : one-hot one-cycle release pulse for the granted slot
//   write_req_desc_o/_idx_o : latched descriptor and granted slot index
//   write_req_desc_valid_o  : descriptor valid towards the reshaper
//   write_req_done_o        : completion forwarded to the reshaper (BUSY only)
//   write_req_done_i        : completion from the write datapath
//   busy_o                  : scheduler not idle
//   timeout_o               : one-cycle watchdog pulse
module xdma_write_req_scheduler
    import xdma_pkg::*;
#(
    parameter int unsigned NumReq        = 4,
    parameter type         xdma_req_desc_t = xdma_pkg::xdma_req_desc_t,
    parameter type         xdma_req_idx_t  = xdma_pkg::xdma_req_idx_t,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  xdma_req_desc_t req_desc_i [NumReq],
    input  logic [NumReq-1:0] req_valid_i,
    output logic [NumReq-1:0] req_release_o,
    output xdma_req_desc_t write_req_desc_o,
    output xdma_req_idx_t  write_req_idx_o,
    output logic           write_req_desc_valid_o,
    output logic           write_req_done_o,
    input  logic           write_req_done_i,
    output logic           busy_o,
    output logic           timeout_o
);

    localparam int unsigned PtrW = $clog2(NumReq);

    xdma_sched_state_e state_q, state_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]   sel_q, sel_d;
    xdma_req_desc_t    desc_q, desc_d;

    logic [PtrW-1:0]   pick_sel;
    logic              pick_any;
    logic              timeout_hit;

    xdma_rr_picker #(
        .NumReq (NumReq),
        .IdxW   (PtrW)
    ) u_picker (
        .valid_i  (req_valid_i),
        .rr_ptr_i (rr_ptr_q),
        .sel_o    (pick_sel),
        .any_o    (pick_any)
    );

`ifdef XDMA_WRITE_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter is zero in every non-BUSY state, so it is clear on BUSY entry.
    always_comb begin
        cnt_d       = (state_q == StBusy) ? cnt_q + CntW'(1) : '0;
        // A real done in the same cycle wins over the watchdog.
        timeout_hit = (state_q == StBusy) && !write_req_done_i &&
                      (cnt_q == CntW'(TimeoutCycles - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles;
    assign timeout_hit        = 1'b0;
`endif

    // State register and latched grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            desc_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            desc_q   <= desc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (pick_any) state_d = StBusy;
            StBusy:    if (write_req_done_i || timeout_hit) state_d = StRelease;
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Grant latch and priority rotation. The latch is only written on a grant,
    // so the descriptor stays stable throughout BUSY and readable afterwards.
    always_comb begin
        sel_d    = sel_q;
        desc_d   = desc_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == StIdle && pick_any) begin
            sel_d  = pick_sel;
            desc_d = req_desc_i[pick_sel];
        end
        if (state_q == StRelease) begin
            rr_ptr_d = (sel_q == PtrW'(NumReq - 1)) ? '0 : sel_q + PtrW'(1);
        end
    end

    // Outputs.
    always_comb begin
        write_req_desc_valid_o = (state_q == StBusy);
        write_req_done_o       = write_req_done_i && (state_q == StBusy);
        busy_o                 = (state_q != StIdle);
        timeout_o              = timeout_hit;
        write_req_desc_o       = desc_q;
        write_req_idx_o        = xdma_req_idx_t'(sel_q);
        req_release_o          = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            req_release_o[i] = (state_q == StRelease) && (sel_q == PtrW'(i));
        end
    end

endmodule

// File: tb/tb_xdma_write_req_scheduler.sv
module tb_xdma_write_req_scheduler;
    import xdma_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    xdma_req_desc_t req_desc [4];
    logic [3:0]     req_valid = '0;
    logic [3:0]     req_release;
    xdma_req_desc_t wr_desc;
    xdma_req_idx_t  wr_idx;
    logic           wr_valid;
    logic           wr_done_o;
    logic           wr_done_i = 1'b0;
    logic           busy;
    logic           timeout;

    always #5 clk = ~clk;

    xdma_write_req_scheduler #(
        .NumReq        (4),
        .TimeoutCycles (16)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .req_desc_i             (req_desc),
        .req_valid_i            (req_valid),
        .req_release_o          (req_release),
        .write_req_desc_o       (wr_desc),
        .write_req_idx_o        (wr_idx),
        .write_req_desc_valid_o (wr_valid),
        .write_req_done_o       (wr_done_o),
        .write_req_done_i       (wr_done_i),
        .busy_o                 (busy),
        .timeout_o              (timeout)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        done;
        logic        poke;
        logic        dv;
        logic [3:0]  idx;
        logic [3:0]  rel;
        logic        doneo;
        logic        busy;
        int unsigned dslot;   // 15 = all-zero descriptor
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic xdma_req_desc_t base_desc(input int unsigned s);
        xdma_req_desc_t d;
        d = '0;
        if (s < 4) begin
            d.remote_addr = 64'(s + 1) << 12;
            d.local_addr  = 64'hA000 + 64'(s);
            d.dma_length  = (s == 2) ? 32'd100 : 32'(16 * (s + 1));
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic [3:0] va, input logic d, input logic p,
                           input logic dv, input logic [3:0] ix, input logic [3:0] rl,
                           input logic dn, input logic b, input int unsigned ds);
        vec_t v;
        v = '{rst: r, valid: va, done: d, poke: p, dv: dv, idx: ix, rel: rl, doneo: dn,
              busy: b, dslot: ds};
        vecs.push_back(v);
    endtask

    task automatic set_desc(input logic poke);
        for (int i = 0; i < 4; i++) req_desc[i] = base_desc(i);
        if (poke) req_desc[0].remote_addr = 64'hDEAD_BEEF_0000_0000;
    endtask

    task automatic chk_desc(input string name, input int unsigned ds);
        xdma_req_desc_t e;
        e = base_desc(ds);
        chk({name, ".raddr"}, wr_desc.remote_addr, e.remote_addr);
        chk({name, ".laddr"}, wr_desc.local_addr, e.local_addr);
        chk({name, ".len"}, 64'(wr_desc.dma_length), 64'(e.dma_length));
    endtask

    initial begin
        int unsigned order [5];
        int unsigned prev;
        set_desc(1'b0);

        // Single request on slot 2, then a done while idle.
        add_vec(1, 4'b0000, 0, 0,  0, 0, 4'b0000, 0, 0, 15);
        add_vec(0, 4'b0000, 0, 0,  0, 0, 4'b0000, 0, 0, 15);
        add_vec(0, 4'b0100, 0, 0,  0, 0, 4'b0000, 0, 0, 15);
        add_vec(0, 4'b0100, 0, 0,  1, 2, 4'b0000, 0, 1, 2);
        add_vec(0, 4'b0100, 1, 0,  1, 2, 4'b0000, 1, 1, 2);
        add_vec(0, 4'b0000, 0, 0,  0, 2, 4'b0100, 0, 1, 2);
        add_vec(0, 4'b0000, 1, 0,  0, 2, 4'b0000, 0, 0, 2);
        add_vec(0, 4'b0000, 0, 0,  0, 2, 4'b0000, 0, 0, 2);

        // All slots pending from reset: grant order 0,1,2,3,0.
        add_vec(1, 4'b1111, 0, 0,  0, 0, 4'b0000, 0, 0, 15);
        order = '{0, 1, 2, 3, 0};
        prev  = 15;
        for (int g = 0; g < 5; g++) begin
            add_vec(0, 4'b1111, 0, 0,  0, (prev > 3) ? 4'd0 : 4'(prev), 4'b0000, 0, 0, prev);
            add_vec(0, 4'b1111, 0, 0,  1, 4'(order[g]), 4'b0000, 0, 1, order[g]);
            add_vec(0, 4'b1111, 0, 0,  1, 4'(order[g]), 4'b0000, 0, 1, order[g]);
            add_vec(0, 4'b1111, 1, 0,  1, 4'(order[g]), 4'b0000, 1, 1, order[g]);
            add_vec(0, 4'b1111, 0, 0,  0, 4'(order[g]), 4'b0001 << order[g], 0, 1, order[g]);
            prev = order[g];
        end

        // Slot 0 withdraws and rewrites its descriptor while BUSY (rr_ptr = 1).
        add_vec(0, 4'b0001, 0, 0,  0, 0, 4'b0000, 0, 0, 0);
        add_vec(0, 4'b0000, 0, 1,  1, 0, 4'b0000, 0, 1, 0);
        add_vec(0, 4'b0000, 0, 1,  1, 0, 4'b0000, 0, 1, 0);
        add_vec(0, 4'b0000, 1, 1,  1, 0, 4'b0000, 1, 1, 0);
        add_vec(0, 4'b0000, 0, 0,  0, 0, 4'b0001, 0, 1, 0);
        // Done in the first BUSY cycle.
        add_vec(0, 4'b0100, 0, 0,  0, 0, 4'b0000, 0, 0, 0);
        add_vec(0, 4'b0000, 1, 0,  1, 2, 4'b0000, 1, 1, 2);
        add_vec(0, 4'b0000, 0, 0,  0, 2, 4'b0100, 0, 1, 2);
        // rr_ptr = 3: search 3,0,1 picks slot 1.
        add_vec(0, 4'b0010, 0, 0,  0, 2, 4'b0000, 0, 0, 2);
        add_vec(0, 4'b0010, 0, 0,  1, 1, 4'b0000, 0, 1, 1);
        // Reset mid-BUSY: async clear, no release, slot 0 first afterwards.
        add_vec(1, 4'b1111, 1, 0,  0, 0, 4'b0000, 0, 0, 15);
        add_vec(0, 4'b1111, 0, 0,  0, 0, 4'b0000, 0, 0, 15);
        add_vec(0, 4'b1111, 0, 0,  1, 0, 4'b0000, 0, 1, 0);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst       = vecs[k].rst;
            req_valid = vecs[k].valid;
            wr_done_i = vecs[k].done;
            set_desc(vecs[k].poke);
            #1;
            chk($sformatf("v%0d.valid", k), 64'(wr_valid), 64'(vecs[k].dv));
            chk($sformatf("v%0d.idx", k), 64'(wr_idx), 64'(vecs[k].idx));
            chk($sformatf("v%0d.release", k), 64'(req_release), 64'(vecs[k].rel));
            chk($sformatf("v%0d.done_o", k), 64'(wr_done_o), 64'(vecs[k].doneo));
            chk($sformatf("v%0d.busy", k), 64'(busy), 64'(vecs[k].busy));
            chk($sformatf("v%0d.timeout", k), 64'(timeout), 64'd0);
            chk_desc($sformatf("v%0d.desc", k), vecs[k].dslot);
        end

        // Slot 0 is in BUSY cycle 1; never send done from here on.
`ifdef XDMA_WRITE_SCHED_TIMEOUT_EN
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            wr_done_i = 1'b0;
            #1;
            chk($sformatf("to%0d.timeout", c), 64'(timeout), (c == 16) ? 64'd1 : 64'd0);
            chk($sformatf("to%0d.valid", c), 64'(wr_valid), 64'd1);
            chk($sformatf("to%0d.done_o", c), 64'(wr_done_o), 64'd0);
        end
        @(negedge clk); #1;
        chk("to.release", 64'(req_release), 64'b0001);
        chk("to.rel_valid", 64'(wr_valid), 64'd0);
        chk("to.rel_timeout", 64'(timeout), 64'd0);
        @(negedge clk); #1;
        chk("to.idle_busy", 64'(busy), 64'd0);
        @(negedge clk); #1;
        chk("to.next_valid", 64'(wr_valid), 64'd1);
        chk("to.next_idx", 64'(wr_idx), 64'd1);
`else
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            wr_done_i = 1'b0;
            #1;
            chk($sformatf("hold%0d.timeout", c), 64'(timeout), 64'd0);
            chk($sformatf("hold%0d.valid", c), 64'(wr_valid), 64'd1);
        end
        @(negedge clk);
        wr_done_i = 1'b1;
        #1;
        chk("hold.done_o", 64'(wr_done_o), 64'd1);
        @(negedge clk);
        wr_done_i = 1'b0;
        #1;
        chk("hold.release", 64'(req_release), 64'b0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xdma_write_req_scheduler.md
# xdma_write_req_scheduler

Round-robin scheduler that shares one `xdma_burst_reshaper` between `NumReq` write-request slots of the XDMA frontend. It picks one pending slot, latches that slot's `xdma_req_desc_t`, and presents the descriptor and slot index to the reshaper. It holds them stable until the write datapath signals completion, then releases the slot and rotates priority.

## Interface
Parameters:
- `NumReq`, default 4: number of request slots, range 2..16.
- `xdma_req_desc_t`, default `xdma_pkg::xdma_req_desc_t`: descriptor type.
- `xdma_req_idx_t`, default `xdma_pkg::xdma_req_idx_t`: slot index type, width ≥ $clog2(`NumReq`).
- `TimeoutCycles`, default 1024: watchdog limit, used only with the macro.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk_i`  in  1  clock.
  - `rst_i`  in  1  asynchronous, active-high reset.
- Request slots:
  - `req_desc_i`  in  `NumReq` × `xdma_req_desc_t`  per-slot descriptor.
  - `req_valid_i`  in  `NumReq`  slot pending; sampled only in IDLE.
  - `req_release_o`  out  `NumReq`  one-hot, one-cycle pulse: slot finished.
- Reshaper side:
  - `write_req_desc_o`  out  `xdma_req_desc_t`  latched descriptor.
  - `write_req_idx_o`  out  `xdma_req_idx_t`  granted slot index.
  - `write_req_desc_valid_o`  out  1  drives reshaper `write_req_desc_valid_i`.
  - `write_req_done_o`  out  1  forwarded completion, drives reshaper `write_req_done_i`.
- Write datapath side:
  - `write_req_done_i`  in  1  current burst finished.
- Status:
  - `busy_o`  out  1  state is not IDLE.
  - `timeout_o`  out  1  one-cycle watchdog pulse.

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - If `req_valid_i` ≠ 0, grant the first set bit at or after `rr_ptr`, searching modulo `NumReq`.
  - On grant, latch `req_desc_i[sel]` into `write_req_desc_o` and `sel` into `write_req_idx_o`, then go to BUSY.
  - If no slot is pending, stay in IDLE.
- BUSY:
  - `write_req_desc_valid_o` = 1; descriptor and index are held constant.
  - Changes to `req_valid_i` or `req_desc_i` are ignored, including withdrawal by the granted slot.
  - On `write_req_done_i` = 1, go to RELEASE.
- RELEASE (one cycle):
  - `write_req_desc_valid_o` = 0.
  - `req_release_o[sel]` = 1.
  - `rr_ptr` ← (`sel`+1) mod `NumReq`.
  - Go to IDLE.
- `write_req_done_o` = `write_req_done_i` & (state == BUSY), combinational. A done seen in IDLE or RELEASE is dropped and not forwarded.
- The latched descriptor stays readable after RELEASE until the next grant. The reshaper must never see a valid descriptor change while valid is high.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, all outputs 0 (descriptor and index zero).
- Grant latency: `req_valid_i` seen at edge t moves to BUSY at t; `write_req_desc_valid_o` = 1 from t+1.
- Done handling:
  - done high in cycle c (BUSY) → RELEASE in c+1, with valid 0 and release pulse.
  - IDLE in c+2; the earliest next valid is c+3.
  - Minimum gap between consecutive bursts is 2 cycles with valid low.
- Done may arrive in the first BUSY cycle; it is accepted.
- Reset asserted mid-burst:
  - Outputs clear immediately (asynchronously).
  - No release pulse is generated.
  - Requesters must treat reset as an abort.
- A single pending slot is re-granted repeatedly. Each grant is preceded by RELEASE and IDLE.

## Configuration
- `XDMA_WRITE_SCHED_TIMEOUT_EN` defined:
  - A $clog2(`TimeoutCycles`)-bit counter clears on entry to BUSY and increments each BUSY cycle without done.
  - At count `TimeoutCycles`−1 with no done: pulse `timeout_o` for one cycle and go to RELEASE as if done. `write_req_done_o` is not asserted for this cycle.
  - Done and timeout in the same cycle count as done; `timeout_o` stays 0.
- Undefined: no counter, `timeout_o` tied to 0, and BUSY waits indefinitely.

## Structure
- `xdma_pkg` holds `xdma_req_desc_t`, `xdma_req_idx_t`, and a `xdma_sched_state_e` enum (IDLE/BUSY/RELEASE).
- One sub-module: `xdma_rr_picker`. It is a combinational round-robin first-one search from `rr_ptr` and outputs `sel` and `any`. All sequencing stays in the top.

## Test plan
- After reset, set `req_valid_i`=4'b0100 with slot 2 `dma_length`=100. Require: valid 1 cycle later, `write_req_idx_o`=2, and the descriptor echoes slot 2. Pulse done → `req_release_o`=4'b0100 the next cycle.
- All four slots pending, done pulsed 3 cycles after each valid. Require grant order 0,1,2,3,0 and `rr_ptr` wrap 3→0.
- Change `req_desc_i[0].remote_addr` and drop `req_valid_i[0]` during BUSY. Require `write_req_desc_o` unchanged and the burst to finish normally.
- Pulse done while IDLE. Require `write_req_done_o`=0, no release pulse, no state change.
- Assert `rst_i` mid-BUSY. Require all outputs 0 asynchronously, no release pulse, and slot 0 granted first after reset.
- With `XDMA_WRITE_SCHED_TIMEOUT_EN` and `TimeoutCycles`=16, never send done. Require `timeout_o` at BUSY cycle 16, release the cycle after, and the next slot granted.
